// File: rtl/loader_pkg.sv
// Shared types and constants for the UART-to-RAM loader and its serial receiver.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        COUNT,
        DATA_HI,
        DATA_LO
    } loader_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rx_state_t;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

endpackage

// File: rtl/uart_ram_loader_if.sv
// RAM write port plus packet status, driven by the loader and observed by the RAM/display side.
interface uart_ram_loader_if #(
    parameter int AW = 8,
    parameter int DW = 16
) ();

    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic          busy;
    logic          done;
    logic          pkt_err;

    modport master (output addr, wdata, we, busy, done, pkt_err);
    modport slave  (input  addr, wdata, we, busy, done, pkt_err);

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, samples mid-bit, reports good bytes or framing errors.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    logic          rx_s;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            prev_q  <= sync_q[1];
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_WAIT: begin
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_ram_loader.sv
// Parses A5/addr/count/data packets from the UART and turns each 16-bit word into a RAM write.
module uart_ram_loader
    import loader_pkg::*;
#(
    parameter int CLK_FREQ           = 50_000_000,
    parameter int BAUD               = 115_200,
    parameter int RAM_WIDTH          = 16,
    parameter int RAM_REGISTER_COUNT = 256,
    parameter int TIMEOUT_CLKS       = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    uart_ram_loader_if.master bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int AW = $clog2(RAM_REGISTER_COUNT);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    loader_state_t        state_q, state_d;
    logic [AW-1:0]        cur_addr_q, cur_addr_d;
    logic [8:0]           remaining_q, remaining_d;
    logic [7:0]           hi_q, hi_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [RAM_WIDTH-1:0] wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic                 done_q, done_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            hi_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            hi_q        <= hi_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
        end
    end

    // DATA_LO keeps the FSM busy through the write cycle, so address/count advance while we is high.
    always_comb begin
        abort       = (state_q != IDLE) && (frame_err || (tmo_q == TMO_LAST));
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        hi_d        = hi_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        done_d      = 1'b0;
        tmo_d       = tmo_q + TW'(1);
        if (state_q == IDLE || byte_valid || abort) begin
            tmo_d = '0;
        end
        case (state_q)
            IDLE: begin
                if (byte_valid && byte_data == HEADER_BYTE) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (byte_valid) begin
                    cur_addr_d = AW'(byte_data);
                    state_d    = COUNT;
                end
            end
            COUNT: begin
                if (byte_valid) begin
                    remaining_d = (byte_data == 8'd0) ? 9'd256 : {1'b0, byte_data};
                    state_d     = DATA_HI;
                end
            end
            DATA_HI: begin
                if (byte_valid) begin
                    hi_d    = byte_data;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (we_q) begin
                    cur_addr_d  = cur_addr_q + AW'(1);
                    remaining_d = remaining_q - 9'd1;
                    state_d     = (remaining_q == 9'd1) ? IDLE : DATA_HI;
                end else if (byte_valid) begin
                    we_d    = 1'b1;
                    addr_d  = cur_addr_q;
                    wdata_d = RAM_WIDTH'({hi_q, byte_data});
                    done_d  = (remaining_q == 9'd1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            we_d    = 1'b0;
            done_d  = 1'b0;
            addr_d  = addr_q;
            wdata_d = wdata_q;
        end
    end

    assign bus.addr    = addr_q;
    assign bus.wdata   = wdata_q;
    assign bus.we      = we_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.pkt_err = abort;

endmodule

// File: doc/uart_ram_loader.md
Name: uart_ram_loader

Overview:
- Feeds the CPU-side write port of the screen/data RAM (addr, wdata, we) from a host PC over a UART serial line.
- Receives framed packets of 16-bit words and writes them to consecutive RAM addresses.
- The VGA/hex display path then shows the new content with no CPU involved.
- Bring-up and debug path until the CPU core drives the same port.

Parameters:
- CLK_FREQ, 50_000_000, clock frequency in Hz.
- BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 434 at defaults).
- RAM_WIDTH, 16, RAM word width. Fixed at 16: two bytes per word.
- RAM_REGISTER_COUNT, 256, RAM depth. Address width AW = $clog2(RAM_REGISTER_COUNT).
- TIMEOUT_CLKS, 50_000_000, idle clocks allowed between bytes inside a packet before it is aborted.

Ports:
- clk  in  1  system clock (CLK_50).
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous UART input, idle high, 8N1, LSB first.
- addr  out  AW  RAM write address.
- wdata  out  RAM_WIDTH  RAM write data.
- we  out  1  RAM write enable, single-cycle pulse per word.
- busy  out  1  high while a packet is in progress (state != IDLE).
- done  out  1  one-cycle pulse with the last write of a packet.
- pkt_err  out  1  one-cycle pulse when a packet is aborted (framing error or timeout).

Behaviour:
- Reset values: addr=0, wdata=0, we=0, busy=0, done=0, pkt_err=0. FSM=IDLE. RX=IDLE. Synchronizer flops=1.
- The reset clock edge overrides all other activity, including mid-byte and mid-packet.
- RX front end:
  - 2-flop synchronizer on rx.
  - Start is detected on the synchronized falling edge.
  - Waits CLKS_PER_BIT/2 clocks, then resamples. If high, it is a glitch: back to idle, no error.
  - Samples 8 data bits every CLKS_PER_BIT clocks, LSB first, then samples the stop bit.
  - Stop=1: byte_valid pulse for 1 cycle with the byte.
  - Stop=0: frame_err pulse, byte dropped. RX then waits for rx high before re-arming.
- Packet format (bytes in order):
  - Header 0xA5.
  - Start address byte (low AW bits used).
  - Count byte N; 0 means 256 words.
  - 2N data bytes, each word high byte first.
- Loader FSM states and transitions (all on byte_valid unless noted):
  - IDLE: byte 0xA5 -> ADDR. Any other byte is ignored silently.
  - ADDR: latch cur_addr -> COUNT.
  - COUNT: latch remaining = (N==0 ? 256 : N) (9-bit) -> DATA_HI.
  - DATA_HI: latch hi byte -> DATA_LO.
  - DATA_LO: on the next clock, we=1, addr=cur_addr, wdata={hi,byte}. Then cur_addr increments modulo RAM_REGISTER_COUNT (wraps 255->0) and remaining decrements. If remaining was 1: done=1 in the same cycle as that we, FSM -> IDLE; else -> DATA_HI.
- Latency: we asserts exactly 1 clock after the byte_valid of the low byte.
- addr and wdata hold their values after the write until the next write.
- Abort: in any state other than IDLE, frame_err or a byte-gap counter reaching TIMEOUT_CLKS causes:
  - FSM -> IDLE, pkt_err pulse, no write for a partial word.
  - Words already written stay written.
- Timeout counter clears on every byte_valid and is held at 0 in IDLE.
- frame_err in IDLE: ignored, no pkt_err.
- Simultaneous frame_err and timeout: a single pkt_err pulse.
- busy = (FSM != IDLE).

Decomposition:
- Package loader_pkg:
  - enum loader_state_t {IDLE, ADDR, COUNT, DATA_HI, DATA_LO}.
  - localparam HEADER_BYTE = 8'hA5.
- Sub-module uart_rx (CLKS_PER_BIT parameter):
  - Inputs: clk, reset, rx.
  - Outputs: byte_valid, byte_data[7:0], frame_err.
- uart_ram_loader instantiates uart_rx plus the packet FSM, the timeout counter and the write outputs.

Test Plan:
- Timing for all tests: CLKS_PER_BIT=8, TIMEOUT_CLKS=200.
- Packet A5 10 02 12 34 AB CD:
  - we pulses twice: addr=0x10 wdata=0x1234, then addr=0x11 wdata=0xABCD.
  - done coincides with the second we. busy falls the next cycle.
  - Each we is exactly 1 clock after the low byte's byte_valid.
- Packet A5 FF 02 11 11 22 22:
  - Writes addr=0xFF wdata=0x1111, then addr=0x00 wdata=0x2222 (wrap).
- Count 0x00 with 512 data bytes:
  - Exactly 256 writes, addresses 0x00..0xFF starting at address 0.
  - One done pulse on the last write.
- Bytes 00 7E before A5 01 01 BE EF:
  - Leading bytes ignored; single write addr=0x01 wdata=0xBEEF.
  - No pkt_err.
- Packet A5 20 03 11 22 then stop bit forced 0 on the next byte:
  - One write 0x20=0x1122, then pkt_err.
  - FSM returns to IDLE. A following valid packet writes normally.
- A5 30 01 44 then silence:
  - pkt_err fires 200 clocks after the last byte_valid; no write.
- reset asserted mid-DATA_LO:
  - All outputs 0 at the next clock, FSM IDLE.
  - The next header starts a fresh packet.
